// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 3-digit 7-segment driver for a BCD value.
// Loads are held until the next frame start so a frame never mixes old and new digits.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] bcd_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        err
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   pending;
    logic [11:0]   display;
    logic          pend_flag;

    logic          slot_end;
    logic          frame_end;
    logic          dead;
    logic [3:0]    hun, ten, one;
    logic [3:0]    digit;
    logic          blanked;
    logic [6:0]    seg_nxt;
    logic [2:0]    an_nxt;
    logic          err_nxt;

    assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == 2'd2);
    assign dead      = (cnt < CW'(DEAD_CYCLES));
    assign hun       = display[11:8];
    assign ten       = display[7:4];
    assign one       = display[3:0];

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        digit = one;
        case (idx)
            2'd1:    digit = ten;
            2'd2:    digit = hun;
            default: digit = one;
        endcase
        // Zero nibbles only, so an invalid digit is never hidden.
        blanked = blank_lz && (((idx == 2'd2) && (hun == 4'd0)) ||
                               ((idx == 2'd1) && (hun == 4'd0) && (ten == 4'd0)));
        seg_nxt = 7'h7F;
        an_nxt  = 3'b111;
        if (!dead && !blanked) begin
            seg_nxt = decode(digit);
            an_nxt  = ~(3'b001 << idx);
        end
        err_nxt = (hun > 4'd9) || (ten > 4'd9) || (one > 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            pending   <= 12'h000;
            pend_flag <= 1'b0;
            display   <= 12'h000;
            seg       <= 7'h7F;
            an        <= 3'b111;
            err       <= 1'b0;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
            err <= err_nxt;

            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // A load on the transfer edge lands in pending and waits a full frame.
            if (frame_end && pend_flag) begin
                display   <= pending;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pending   <= bcd_in;
                pend_flag <= 1'b1;
            end
        end
    end
endmodule
